// File: rtl/counting_pkg.sv
// Shared encodings for the frame scheduler and its sequence detector.
package counting_pkg;

    typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} det_state_t;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, REPORT = 2'd2} sched_state_t;

    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_10 = 2'b10;
    localparam logic [1:0] SYM_11 = 2'b11;

endpackage

// File: rtl/counting_det.sv
// Four-state 2-bit symbol sequence detector; match flags the D2->D3 step.
module counting_det
    import counting_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       adv,
    input  logic [1:0] sym,
    output logic [1:0] state,
    output logic       match
);

    det_state_t st, st_nxt;

    always_comb begin
        st_nxt = st;
        if (adv) begin
            case (st)
                D0: st_nxt = (sym == SYM_01) ? D1 : D0;
                D1: st_nxt = (sym == SYM_01) ? D1 : (sym == SYM_10) ? D2 : D0;
                D2: st_nxt = (sym == SYM_01) ? D1 : (sym == SYM_10) ? D2 :
                             (sym == SYM_11) ? D3 : D0;
                D3: st_nxt = (sym == SYM_01) ? D1 : (sym == SYM_10) ? D0 : D3;
                default: st_nxt = D0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) st <= D0;
        else            st <= st_nxt;
    end

    assign state = st;
    assign match = adv && (st == D2) && (sym == SYM_11);

endmodule

// File: rtl/counting_sched.sv
// Frame-level round-robin scheduler sharing one sequence detector between two
// requesters; reports per-frame match count and final detect status.
module counting_sched
    import counting_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_sym,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_sym,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_src,
    output logic [CNT_W-1:0] res_count,
    output logic             res_hold,
    output logic             busy
);

    sched_state_t     st, st_nxt;
    logic             owner, owner_nxt, last_srv;
    logic [1:0]       vld, rdy;
    logic             own_vld, own_last, accept, match;
    logic [1:0]       own_sym, det_st;
    logic [CNT_W-1:0] cnt, cnt_q;
    logic             src_q, hold_q;

    assign vld      = {req1_valid, req0_valid};
    assign own_vld  = owner ? req1_valid : req0_valid;
    assign own_sym  = owner ? req1_sym   : req0_sym;
    assign own_last = owner ? req1_last  : req0_last;
    assign accept   = (st == RUN) && own_vld && rdy[owner];

    always_comb begin
        st_nxt    = st;
        owner_nxt = owner;
        case (st)
            IDLE: if (|vld) begin
                st_nxt    = RUN;
                // on a tie, the requester not served last wins
                owner_nxt = (&vld) ? ~last_srv : vld[1];
            end
            RUN:     if (accept && own_last) st_nxt = REPORT;
            REPORT:  st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            owner    <= 1'b0;
            last_srv <= 1'b1;
            rdy      <= 2'b00;
            cnt      <= '0;
            cnt_q    <= '0;
            src_q    <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            st    <= st_nxt;
            owner <= owner_nxt;
            // ready comes from next state/owner only, never from valid
            rdy   <= (st_nxt == RUN) ? (owner_nxt ? 2'b10 : 2'b01) : 2'b00;
            if (st == IDLE)
                cnt <= '0;
            else if (match && (cnt != {CNT_W{1'b1}}))
                cnt <= cnt + CNT_W'(1);
            if (st == REPORT) begin
                last_srv <= owner;
                src_q    <= owner;
                cnt_q    <= cnt;
                hold_q   <= (det_st == D3);
            end
        end
    end

    counting_det u_det (
        .clk   (clk),
        .rst   (rst),
        .clr   (st == IDLE),
        .adv   (accept),
        .sym   (own_sym),
        .state (det_st),
        .match (match)
    );

    // live values during REPORT, held copies afterwards
    assign res_valid  = (st == REPORT);
    assign res_src    = (st == REPORT) ? owner : src_q;
    assign res_count  = (st == REPORT) ? cnt : cnt_q;
    assign res_hold   = (st == REPORT) ? (det_st == D3) : hold_q;
    assign busy       = (st != IDLE);
    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];

endmodule

// File: tb/tb_counting_sched.sv
// Scoreboard bench: per-requester symbol/expected queues, a driver process,
// and a monitor comparing results from an 8-bit and a 2-bit counter instance.
module tb_counting_sched;

    typedef logic [1:0] symq_t[$];
    typedef struct {
        int c8;
        int c2;
        bit hold;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
    logic [1:0] req0_sym = 2'b00, req1_sym = 2'b00;
    logic       req0_ready, req1_ready, res_valid, res_src, res_hold, busy;
    logic [7:0] res_count;
    logic       b_req0_ready, b_req1_ready, b_res_valid, b_res_src, b_res_hold, b_busy;
    logic [1:0] b_res_count;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, gap_pct = 0, res_cyc = 0;
    int last_acc_cyc[2];
    logic [1:0] sq0[$], sq1[$];
    bit lq0[$], lq1[$];
    exp_t eq0[$], eq1[$];
    bit srclog[$];
    bit acc0 = 0, acc1 = 0;
    bit hold_chk = 0;
    exp_t hold_e;
    bit hold_src;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    counting_sched #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_sym(req0_sym), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_sym(req1_sym), .req1_last(req1_last), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_src(res_src), .res_count(res_count), .res_hold(res_hold),
        .busy(busy)
    );

    counting_sched #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_sym(req0_sym), .req0_last(req0_last), .req0_ready(b_req0_ready),
        .req1_valid(req1_valid), .req1_sym(req1_sym), .req1_last(req1_last), .req1_ready(b_req1_ready),
        .res_valid(b_res_valid), .res_src(b_res_src), .res_count(b_res_count), .res_hold(b_res_hold),
        .busy(b_busy)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: walk the detector transition table, count D2 --11--> D3 steps.
    function automatic exp_t model(symq_t s);
        int nxt [4][4] = '{'{0, 1, 0, 0}, '{0, 1, 2, 0}, '{0, 1, 2, 3}, '{3, 1, 0, 3}};
        int st = 0, m = 0;
        exp_t r;
        foreach (s[i]) begin
            if (st == 2 && s[i] == 2'b11) m++;
            st = nxt[st][s[i]];
        end
        r.c8   = (m > 255) ? 255 : m;
        r.c2   = (m > 3) ? 3 : m;
        r.hold = (st == 3);
        return r;
    endfunction

    task automatic push_frame(bit src, symq_t s, exp_t e);
        foreach (s[i]) begin
            if (src) begin sq1.push_back(s[i]); lq1.push_back(i == s.size() - 1); end
            else     begin sq0.push_back(s[i]); lq0.push_back(i == s.size() - 1); end
        end
        if (src) eq1.push_back(e);
        else     eq0.push_back(e);
    endtask

    task automatic push_dir(bit src, symq_t s, int c8, int c2, bit hold);
        exp_t e;
        e.c8 = c8; e.c2 = c2; e.hold = hold;
        push_frame(src, s, e);
    endtask

    task automatic push_rand(bit src, int len);
        symq_t s;
        for (int i = 0; i < len; i++) s.push_back(2'($urandom_range(3)));
        push_frame(src, s, model(s));
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while ((eq0.size() != 0 || eq1.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) chk("timeout_wait_results", 1, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Driver: inputs change at negedge; acceptance decided by valid&ready then.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            sq0.delete(); lq0.delete(); sq1.delete(); lq1.delete();
            req0_valid = 0; req1_valid = 0; acc0 = 0; acc1 = 0;
        end else begin
            if (acc0) begin sq0.delete(0); lq0.delete(0); end
            if (acc1) begin sq1.delete(0); lq1.delete(0); end
            req0_valid = (sq0.size() != 0) && (int'($urandom_range(99)) >= gap_pct);
            req1_valid = (sq1.size() != 0) && (int'($urandom_range(99)) >= gap_pct);
            req0_sym  = (sq0.size() != 0) ? sq0[0] : 2'($urandom_range(3));
            req0_last = (sq0.size() != 0) ? lq0[0] : 1'b0;
            req1_sym  = (sq1.size() != 0) ? sq1[0] : 2'($urandom_range(3));
            req1_last = (sq1.size() != 0) ? lq1[0] : 1'b0;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (acc0 && req0_last) last_acc_cyc[0] = cyc;
            if (acc1 && req1_last) last_acc_cyc[1] = cyc;
        end
    end

    // Monitor
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("ready_exclusive", {31'd0, req0_ready & req1_ready}, 0);
            chk("w2_ready_busy", {b_busy, b_req1_ready, b_req0_ready}, {busy, req1_ready, req0_ready});
            if (hold_chk) begin
                hold_chk = 0;
                chk("res_count_held", res_count, hold_e.c8);
                chk("res_hold_held", res_hold, hold_e.hold);
                chk("res_src_held", res_src, hold_src);
            end
            if (res_valid || b_res_valid) begin
                chk("w2_res_valid", b_res_valid, res_valid);
                chk("w2_res_src", b_res_src, res_src);
                if ((res_src ? eq1.size() : eq0.size()) == 0) begin
                    chk("unexpected_res_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = res_src ? eq1.pop_front() : eq0.pop_front();
                    chk("res_count", res_count, e.c8);
                    chk("res_count_w2", b_res_count, e.c2);
                    chk("res_hold", res_hold, e.hold);
                    chk("res_hold_w2", b_res_hold, e.hold);
                    chk("res_latency", cyc, last_acc_cyc[res_src] + 1);
                    hold_e = e; hold_src = res_src; hold_chk = 1;
                end
                srclog.push_back(res_src);
                res_cyc = cyc;
            end
        end
    end

    initial begin
        symq_t q;
        int k;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_src", res_src, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_res_hold", res_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_w2_outputs", {b_res_valid, b_res_count, b_busy}, 0);
        rst = 0;

        @(posedge clk); #1;
        k = cyc;
        q = '{2'b01, 2'b10, 2'b11, 2'b00}; push_dir(0, q, 1, 1, 1);
        wait_done(100);
        chk("first_frame_latency", res_cyc, k + 5);

        q = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10, 2'b11}; push_dir(1, q, 2, 2, 1);
        q = '{2'b01, 2'b10, 2'b11, 2'b10};                      push_dir(1, q, 1, 1, 0);
        wait_done(100);

        q = '{2'b01, 2'b10}; push_dir(0, q, 0, 0, 0);
        q = '{2'b11};        push_dir(0, q, 0, 0, 0);
        wait_done(100);

        q = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
        push_dir(0, q, 4, 3, 1);
        wait_done(100);

        // tie right after reset: grants must alternate starting with requester 0
        rst = 1; @(posedge clk); #1; rst = 0;
        srclog.delete();
        q = '{2'b01, 2'b10}; push_dir(0, q, 0, 0, 0);
        q = '{2'b10, 2'b11}; push_dir(1, q, 0, 0, 0);
        q = '{2'b11, 2'b00}; push_dir(0, q, 0, 0, 0);
        q = '{2'b00, 2'b01}; push_dir(1, q, 0, 0, 0);
        wait_done(100);
        chk("tie_grant_count", srclog.size(), 4);
        if (srclog.size() >= 4) begin
            chk("tie_grant0", srclog[0], 0);
            chk("tie_grant1", srclog[1], 1);
            chk("tie_grant2", srclog[2], 0);
            chk("tie_grant3", srclog[3], 1);
        end

        gap_pct = 25;
        for (int i = 0; i < 40; i++) push_rand(1'($urandom_range(1)), int'($urandom_range(12, 1)));
        wait_done(5000);

        // reset in mid-frame with owner valid toggling
        gap_pct = 40;
        push_rand(0, 30);
        repeat (8) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        rst = 1;
        eq0.delete(); eq1.delete();
        @(posedge clk); #1;
        chk("midrst_ready", {req1_ready, req0_ready}, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_busy", busy, 0);
        rst = 0;
        q = '{2'b01, 2'b10, 2'b11}; push_dir(0, q, 1, 1, 1);
        wait_done(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/counting_sched.md
# counting_sched

Frame-level scheduler that shares one 2-bit-symbol sequence detector between two requesters. It grants the detector to one requester for a whole frame, feeds that frame's symbols at one per cycle, and counts detections. At frame end it reports the count and the final detector status. It sits between the symbol sources and downstream logic that consumes per-frame detection results.

## Interface
- `CNT_W`, 8, width of the per-frame match counter (saturating).

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a symbol.
- `req0_sym`  in  2  requester 0 symbol.
- `req0_last`  in  1  requester 0 symbol is the last of its frame.
- `req0_ready`  out  1  requester 0 symbol accepted this cycle when `req0_valid` is also high.
- `req1_valid`, `req1_sym`, `req1_last`, `req1_ready`: same as requester 0.
- `res_valid`  out  1  one-cycle pulse: frame result valid.
- `res_src`  out  1  requester that owned the reported frame.
- `res_count`  out  CNT_W  number of detections in the frame.
- `res_hold`  out  1  detector was in the detect state after the frame's last symbol.
- `busy`  out  1  a frame is granted or being reported.

## Operation
- Detector states are D0, D1, D2 and D3. Detection is asserted in D3.
- D0: `01`->D1; any other symbol->D0.
- D1: `01`->D1; `10`->D2; `11` or `00`->D0.
- D2: `01`->D1; `10`->D2; `11`->D3; `00`->D0.
- D3: `01`->D1; `00` or `11`->D3; `10`->D0.
- The detector advances only on an accepted symbol, meaning owner `ready` and owner `valid` are both high.
- Match event: an accepted `11` while the detector is in D2, i.e. the D2->D3 transition. Staying in D3 is not a new match.
- `res_count` increments by 1 per match event and saturates at all-ones.
- Scheduler states are IDLE, RUN and REPORT.
  - IDLE: the detector is forced to D0 and the count to 0. If any `reqN_valid` is high, grant it and go to RUN. If both are high, grant the requester not served last (round-robin).
  - RUN: the owner's `ready` is 1 and the other requester's is 0. Accepting a symbol with `last`=1 goes to REPORT.
  - REPORT: `res_valid`=1 for exactly one cycle. `res_count` includes the last symbol's match. `res_hold`=(detector==D3). Then go to IDLE and record the owner as last served.
- Owner valid low during RUN: stall, hold all state, no timeout.
- `res_src`, `res_count` and `res_hold` hold their values until the next REPORT.

## Timing
- Reset values: `req0_ready`=0, `req1_ready`=0, `res_valid`=0, `res_src`=0, `res_count`=0, `res_hold`=0, `busy`=0, state IDLE, detector D0, last-served=1. After reset, requester 0 wins the first tie.
- `reqN_ready` is a registered function of scheduler state and owner only. It never depends combinationally on `valid`.
- Latency: valid seen in IDLE at cycle t -> owner ready at t+1. Last symbol accepted at cycle u -> `res_valid` at u+1 -> IDLE at u+2.
- Throughput inside a frame is 1 symbol/cycle. Per-frame overhead is 2 cycles (IDLE + REPORT).
- One-symbol frame (first symbol has `last`=1): RUN lasts one cycle, then REPORT.
- The detector is always cleared between frames. No state carries across frames or requesters.
- `rst` mid-frame: the next cycle is IDLE with readies 0. No `res_valid` is issued for the aborted frame, and the count restarts at 0.
- `busy`=1 in RUN and REPORT.

## Structure
- The shared package `counting_pkg` holds the detector state encodings D0..D3 (2-bit), the scheduler state encodings IDLE/RUN/REPORT, and the symbol constants `01`, `10`, `11`.
- Sub-module `counting_det` contains the detector. Its ports are `clk`, `rst`, `clr` (sync, forces D0), `adv`, `sym[1:0]`, `state[1:0]` and `match` (combinational: `adv` && state==D2 && sym==`11`).
- The scheduler FSM, arbiter, counter and result registers live in `counting_sched`.

## Test plan
- Req0 frame `01`,`10`,`11`,`00`(last) -> one `res_valid` pulse, `res_src`=0, `res_count`=1, `res_hold`=1.
- Req1 frame `01`,`10`,`11`,`10`,`01`,`10`,`11`(last) -> `res_src`=1, `res_count`=2, `res_hold`=1. Also frame `01`,`10`,`11`,`10`(last) -> count 1, hold 0.
- Frame A `01`,`10`(last) then frame B `11`(last) -> B reports count 0, hold 0, proving the detector is cleared between frames.
- Both valid continuously right after reset, 2-symbol frames -> grants alternate 0,1,0,1. The non-owner's ready stays 0 throughout.
- `CNT_W`=2, frame containing four `01`,`10`,`11` groups -> `res_count`=3 (saturated).
- `rst` asserted in the middle of a req0 frame with owner valid toggling -> readies 0 next cycle, no `res_valid`. The next frame `01`,`10`,`11`(last) reports count 1.
